mult_seq_unit: RTL and testbench

- Multi-cycle HI/LO multiplier. It consumes the alucontrol/hassign encoding produced by the ALU decoder: alucontrol = 3'b100 means multiply, and hassign selects signed (MULT) or unsigned (MULTU).
- Sits beside the single-cycle ALU in the execute stage.
- Performs a radix-2 shift-add multiply on operand magnitudes, then applies a sign fix-up.
- Raises busy so the pipeline stalls, and pulses done when HI/LO are updated.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/cond_neg.sv | 14 +
 rtl/mult_seq_unit.sv | 136 +++++++++++++
 tb/tb_mult_seq_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, multiplier FSM states and the
// default datapath width used by the execute-stage arithmetic units.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MULT = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement: passes the value through, or negates it
// modulo 2^W when neg_i is set. Used for operand magnitudes and the final
// sign fix-up of the product.
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_seq_unit.sv
// Multi-cycle HI/LO multiplier for the execute stage. Runs a radix-2
// shift-add over operand magnitudes, then negates the 2*WIDTH product when
// the signed operands had opposite signs. busy stalls the pipeline while the
// unit works; done pulses for one cycle when hi/lo have been updated.
module mult_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       alucontrol,
    input  logic             hassign,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic                   neg_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;

    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [2*WIDTH-1:0]     acc_d;
    logic                   neg_d;
    logic                   accept;

    // Signed operands are reduced to magnitudes; 0x80..0 maps to itself,
    // which is the correct unsigned magnitude once the product is 2*WIDTH.
    cond_neg #(.W(WIDTH)) u_mag_a (
        .val_i (a),
        .neg_i (hassign & a[WIDTH-1]),
        .res_o (mag_a)
    );

    cond_neg #(.W(WIDTH)) u_mag_b (
        .val_i (b),
        .neg_i (hassign & b[WIDTH-1]),
        .res_o (mag_b)
    );

    cond_neg #(.W(2*WIDTH)) u_fix (
        .val_i (acc_q),
        .neg_i (neg_q),
        .res_o (prod_fix)
    );

    // A new multiply is taken only when the unit is free and no flush is pending.
    always_comb begin
        accept = start && (alucontrol == ALU_MULT) && !flush &&
                 ((state_q == IDLE) || (state_q == DONE));
        neg_d  = hassign & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Control FSM and datapath registers; flush overrides everything but reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q  <= CALC;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        neg_q    <= neg_d;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q    <= prod_fix[WIDTH-1:0];
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed corner cases plus random
// operands compared against a plain 64-bit arithmetic reference.
module tb_mult_seq_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  alucontrol;
    logic        hassign;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mult_seq_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .hassign    (hassign),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product straight from arithmetic: sign-extend or zero-extend
    // each operand to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    // Drive a multiply request for the coming edge, release it just after.
    task automatic issue_now(input logic [31:0] x, input logic [31:0] y, input logic s);
        start      = 1'b1;
        alucontrol = 3'b100;
        hassign    = s;
        a          = x;
        b          = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sample on falling edges, numbering cycles from first_c; bounded wait.
    task automatic wait_done(input int first_c, output int done_c, output int busy_n,
                             output logic [31:0] hi_o, output logic [31:0] lo_o);
        done_c = -1;
        busy_n = 0;
        hi_o   = hi;
        lo_o   = lo;
        for (int c = first_c; c < first_c + 100; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_c = c;
                hi_o   = hi;
                lo_o   = lo;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output int done_c, output int busy_n,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        @(negedge clk);
        issue_now(x, y, s);
        wait_done(1, done_c, busy_n, hi_o, lo_o);
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        start      = 1'b0;
        alucontrol = 3'b000;
        hassign    = 1'b0;
        flush      = 1'b0;
        a          = '0;
        b          = '0;
        #3;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all zero",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_unsigned_max();
        int dc, bn;
        logic [31:0] h, l;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, dc, bn, h, l);
        checks++;
        if (dc !== 34) begin
            failures++;
            $display("[TB] FAIL umax_done_cycle: got %0d, want 34", dc);
        end
        checks++;
        if (bn !== 33) begin
            failures++;
            $display("[TB] FAIL umax_busy_cycles: got %0d, want 33", bn);
        end
        checks++;
        if ({h, l} !== 64'hFFFFFFFE_00000001) begin
            failures++;
            $display("[TB] FAIL umax_result: got %h_%h, want fffffffe_00000001", h, l);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL umax_after_done: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_signed();
        logic [31:0] xs [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] ys [4] = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic        ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] ex [4] = '{64'hFFFFFFFF_FFFFFFF1, 64'h00000000_00000001,
                                64'h40000000_00000000, 64'h40000000_00000000};
        int dc, bn;
        logic [31:0] h, l;
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ys[i], ss[i], dc, bn, h, l);
            checks++;
            if ({h, l} !== ex[i] || dc !== 34) begin
                failures++;
                $display("[TB] FAIL signed_case%0d: got %h_%h at cycle %0d, want %h at cycle 34",
                         i, h, l, dc, ex[i]);
            end
        end
    endtask

    task automatic test_filter();
        logic [31:0] h0, l0;
        int busy_seen, done_seen;
        h0 = hi;
        l0 = lo;
        busy_seen = 0;
        done_seen = 0;
        @(negedge clk);
        start      = 1'b1;
        alucontrol = 3'b010;
        hassign    = 1'b0;
        a          = 32'd5;
        b          = 32'd5;
        @(posedge clk);
        #1;
        start      = 1'b0;
        alucontrol = 3'b100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        checks++;
        if (busy_seen !== 0 || done_seen !== 0) begin
            failures++;
            $display("[TB] FAIL filter_activity: got busy=%0d done=%0d cycles, want 0 0",
                     busy_seen, done_seen);
        end
        checks++;
        if (hi !== h0 || lo !== l0) begin
            failures++;
            $display("[TB] FAIL filter_hilo: got %h_%h, want %h_%h", hi, lo, h0, l0);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bn;
        logic [31:0] h, l;
        run_op(32'd6, 32'd7, 1'b0, dc, bn, h, l);
        checks++;
        if ({h, l} !== 64'd42 || dc !== 34) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h_%h at cycle %0d, want 42 at 34", h, l, dc);
        end
        issue_now(32'd2, 32'd3, 1'b0);
        wait_done(1, dc, bn, h, l);
        checks++;
        if (dc !== 34 || bn !== 33) begin
            failures++;
            $display("[TB] FAIL b2b_timing: got done cycle %0d busy %0d, want 34 33", dc, bn);
        end
        checks++;
        if ({h, l} !== 64'd6) begin
            failures++;
            $display("[TB] FAIL b2b_result: got %h_%h, want 6", h, l);
        end
    endtask

    task automatic test_ignore_during_calc();
        int dc, bn;
        logic [31:0] h, l;
        @(negedge clk);
        issue_now(32'd5, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        issue_now(32'd100, 32'd100, 1'b0);
        wait_done(5, dc, bn, h, l);
        checks++;
        if (dc !== 34 || {h, l} !== 64'd35) begin
            failures++;
            $display("[TB] FAIL ignore_in_calc: got %h_%h at cycle %0d, want 35 at 34", h, l, dc);
        end
    endtask

    task automatic test_flush();
        int dc, bn, done_seen, busy_seen;
        logic [31:0] h, l;
        run_op(32'h00000022, 32'h80000001, 1'b0, dc, bn, h, l);
        checks++;
        if (h !== 32'h11 || l !== 32'h22) begin
            failures++;
            $display("[TB] FAIL flush_setup: got %h_%h, want 00000011_00000022", h, l);
        end
        @(negedge clk);
        issue_now(32'd7, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_busy: got busy=%b done=%b, want 0 0", busy, done);
        end
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (done_seen !== 0 || busy_seen !== 0 || hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("[TB] FAIL flush_after: got done=%0d busy=%0d hi=%h lo=%h, want 0 0 11 22",
                     done_seen, busy_seen, hi, lo);
        end
    endtask

    task automatic test_reset_midop();
        int dc, bn;
        logic [31:0] h, l;
        @(negedge clk);
        issue_now(32'h12345678, 32'h9ABCDEF0, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failures++;
            $display("[TB] FAIL reset_midop: got busy=%b done=%b hi=%h lo=%h, want all zero",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_op(32'd3, 32'd4, 1'b0, dc, bn, h, l);
        checks++;
        if ({h, l} !== 64'd12 || dc !== 34) begin
            failures++;
            $display("[TB] FAIL reset_recover: got %h_%h at cycle %0d, want 12 at 34", h, l, dc);
        end
    endtask

    task automatic test_random();
        int dc, bn;
        logic [31:0] h, l, x, y;
        logic s;
        logic [63:0] want;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 7))
                0:       x = 32'h80000000;
                1:       x = 32'hFFFFFFFF;
                2:       x = 32'h0;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       y = 32'h80000000;
                1:       y = 32'h00000001;
                2:       y = 32'h7FFFFFFF;
                default: y = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            want = ref_prod(x, y, s);
            run_op(x, y, s, dc, bn, h, l);
            checks++;
            if ({h, l} !== want || dc !== 34) begin
                failures++;
                $display("[TB] FAIL random%0d: %h*%h s=%b got %h_%h at cycle %0d, want %h at 34",
                         i, x, y, s, h, l, dc, want);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_filter();
        test_back_to_back();
        test_ignore_during_calc();
        test_flush();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
